// File: rtl/bank_biu_rdata_pack.sv
// Read-return packer: pairs two 128-bit read beats into one 256-bit line,
// checks burst integrity, and queues lines for the ISU through a small FIFO.
module bank_biu_rdata_pack #(
  parameter int BEAT_W     = 128,
  parameter int ID_W       = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mem_biu_rvalid_i,
  output logic                mem_biu_rready_o,
  input  logic [BEAT_W-1:0]   mem_biu_rdata_i,
  input  logic [ID_W-1:0]     mem_biu_rid_i,
  input  logic [1:0]          mem_biu_rresp_i,
  input  logic                mem_biu_rlast_i,
  output logic                biu_isu_rvalid_o,
  input  logic                biu_isu_rready_i,
  output logic [2*BEAT_W-1:0] biu_isu_rdata_o,
  output logic [ID_W-1:0]     biu_isu_rid_o,
  output logic                biu_isu_rerr_o,
  output logic                biu_proto_err_o,
  output logic [15:0]         biu_line_cnt_o,
  output logic                biu_fsm_state_o
);
  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready.

  localparam int LINE_W = 2 * BEAT_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, HALF = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   hold_data_q;
  logic [ID_W-1:0]     hold_id_q;
  logic                hold_err_q;

  logic [LINE_W-1:0]   mem_data_q [FIFO_DEPTH];
  logic [ID_W-1:0]     mem_id_q   [FIFO_DEPTH];
  logic                mem_err_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                full, empty, beat_acc, push, pop;
  logic                beat0_proto, beat1_proto, line_err;
  logic                proto_err_q;
  logic [15:0]         line_cnt_q;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Ready in HALF looks only at the registered fill level, never at the ISU ready.
  assign mem_biu_rready_o = (state_q == IDLE) ? 1'b1 : !full;
  assign beat_acc         = mem_biu_rvalid_i & mem_biu_rready_o;
  assign pop              = biu_isu_rvalid_o & biu_isu_rready_i;

  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    beat0_proto = 1'b0;
    beat1_proto = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat_acc) begin
          beat0_proto = mem_biu_rlast_i;
          state_d     = HALF;
        end
      end
      HALF: begin
        if (beat_acc) begin
          beat1_proto = !mem_biu_rlast_i || (mem_biu_rid_i != hold_id_q);
          push        = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_err = hold_err_q | (mem_biu_rresp_i != 2'b00) | beat1_proto;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_id_q   <= '0;
      hold_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && beat_acc) begin
        hold_data_q <= mem_biu_rdata_i;
        hold_id_q   <= mem_biu_rid_i;
        hold_err_q  <= (mem_biu_rresp_i != 2'b00) | mem_biu_rlast_i;
      end
      if (beat0_proto || beat1_proto) proto_err_q <= 1'b1;
    end
  end

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_id_q[i]   <= '0;
        mem_err_q[i]  <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      line_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q] <= {mem_biu_rdata_i, hold_data_q};
        mem_id_q[wr_ptr_q]   <= hold_id_q;
        mem_err_q[wr_ptr_q]  <= line_err;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        line_cnt_q <= line_cnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign biu_isu_rvalid_o = !empty;
  assign biu_isu_rdata_o  = mem_data_q[rd_ptr_q];
  assign biu_isu_rid_o    = mem_id_q[rd_ptr_q];
  assign biu_isu_rerr_o   = mem_err_q[rd_ptr_q];
  assign biu_proto_err_o  = proto_err_q;
  assign biu_line_cnt_o   = line_cnt_q;
  assign biu_fsm_state_o  = (state_q == HALF);

endmodule
